// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one radix-2 Booth sequential multiplier among NREQ requesters.
// Each accepted request yields one signed 2W-bit product, tagged with the requester index.
module booth_mult_scheduler #(
    parameter int unsigned W    = 16,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*W-1:0]      req_a,
    input  logic [NREQ*W-1:0]      req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [2*W-1:0]         rsp_product,
    output logic                   busy
);

    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [W:0]      r_a;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_m;
    logic            r_qm1;
    logic [CW-1:0]   r_cnt;
    logic            r_rsp_valid;

    logic            w_grant_any;
    logic [IDW-1:0]  w_grant_idx;
    logic [W:0]      w_a_sum;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int unsigned w_cand;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = 32'(r_ptr) + k;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (!w_grant_any && req_valid[IDW'(w_cand)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = IDW'(w_cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    req_ready   = NREQ'(1) << w_grant_idx;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Booth add/subtract; A carries one extra bit so -M of the most negative M fits.
    always_comb begin
        w_a_sum = r_a;
        case ({r_q[0], r_qm1})
            2'b01:   w_a_sum = r_a + {r_m[W-1], r_m};
            2'b10:   w_a_sum = r_a - {r_m[W-1], r_m};
            default: w_a_sum = r_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_qm1       <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_m   <= req_a[32'(w_grant_idx)*W +: W];
                        r_q   <= req_b[32'(w_grant_idx)*W +: W];
                        r_a   <= '0;
                        r_qm1 <= 1'b0;
                        r_cnt <= CW'(W - 1);
                        r_id  <= w_grant_idx;
                        r_ptr <= w_grant_idx;
                    end
                end
                ST_CALC: begin
                    r_a   <= {w_a_sum[W], w_a_sum[W:1]};
                    r_q   <= {w_a_sum[0], r_q[W-1:1]};
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_id;
    assign rsp_product = {r_a[W-1:0], r_q};
    assign busy        = (r_state != ST_IDLE);

endmodule
